frame_char_streamer: RTL
========================

FRAME_CHAR_STREAMER -- requirements
Module: frame_char_streamer

Interface
REQ-001 SHALL have parameter CHAR_W, default 7, bits per character code.
REQ-002 SHALL have parameter NUM_CHARS, default 192, characters per frame; FRAME_W = CHAR_W*NUM_CHARS = 1344.
REQ-003 SHALL have port clk, input, 1, rising-edge clock.
REQ-004 SHALL have port rst, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port frame, input, FRAME_W, frame from the game FSM; char 0 in bits [FRAME_W-1 -: CHAR_W].
REQ-006 SHALL have port frame_update, input, 1, single-cycle request to stream the current frame.
REQ-007 SHALL have port wr_valid, output, 1, character write offered to the text buffer.
REQ-008 SHALL have port wr_ready, input, 1, text buffer accepts a write this cycle.
REQ-009 SHALL have port wr_addr, output, 8, character index 0..NUM_CHARS-1.
REQ-010 SHALL have port wr_data, output, CHAR_W, character code.
REQ-011 SHALL have port busy, output, 1, high in STREAM and DONE.
REQ-012 SHALL have port done, output, 1, one-cycle pulse after the last character is accepted.

Function
REQ-013 SHALL implement states IDLE, STREAM, DONE.
REQ-014 IDLE + frame_update=1 at edge N: SHALL capture frame into a shadow shift register, set wr_addr=0, enter STREAM; wr_valid=1 from cycle N+1.
REQ-015 wr_data SHALL always equal the top CHAR_W bits of the shadow register; frame changes after capture SHALL NOT affect the stream.
REQ-016 Transfer SHALL occur only on an edge with wr_valid=1 and wr_ready=1; on transfer, shadow shifts left by CHAR_W (zero fill) and wr_addr increments by 1.
REQ-017 Without a transfer, wr_valid, wr_addr, wr_data SHALL hold stable; wr_valid SHALL NOT drop before the transfer.
REQ-018 Transfer at wr_addr=NUM_CHARS-1: SHALL enter DONE, wr_valid=0, wr_addr wraps to 0; no address beyond NUM_CHARS-1 is ever presented.
REQ-019 DONE SHALL last exactly one cycle with done=1, then go to IDLE or, if pending=1, recapture frame and enter STREAM at wr_addr 0, clearing pending.
REQ-020 frame_update in STREAM or DONE (including the cycle of the last transfer) SHALL set pending; multiple requests collapse to one.
REQ-021 frame_update in IDLE with pending=0 SHALL behave per REQ-014; with wr_ready tied 1, one frame takes NUM_CHARS cycles of wr_valid plus one DONE cycle.
REQ-022 wr_ready while wr_valid=0 SHALL be ignored.

Reset
REQ-023 rst=0 SHALL asynchronously force state IDLE, shadow 0, pending 0, wr_valid 0, wr_addr 0, wr_data 0, busy 0, done 0.
REQ-024 Reset mid-STREAM SHALL abort the frame; after release, no writes occur until a new frame_update.

Structure
REQ-025 CHAR_W, NUM_CHARS, FRAME_W and the state encoding (2-bit, IDLE=0, STREAM=1, DONE=2) SHALL live in the shared package game_pkg.
REQ-026 SHALL be a single module, no sub-modules; shadow register is a shift register, not a 192-way mux.

Verification
REQ-027 Reset, frame char0=7'h30, char191=7'h46, update pulse, wr_ready=1 -> 192 writes addr 0..191 consecutive, first data 7'h30, last 7'h46, done pulse at cycle 194.
REQ-028 wr_ready toggling 1,0,0,1 pattern -> addr/data stable while stalled, no skipped or duplicated index, all 192 delivered.
REQ-029 frame changed to all-7'h20 at addr 50 without update -> remaining data still from captured frame.
REQ-030 Two update pulses during STREAM plus one coincident with last transfer -> exactly one extra full frame, second capture taken in DONE cycle.
REQ-031 rst low at addr 100 with wr_valid=1 -> wr_valid 0 immediately, all outputs 0; no writes after release until update.
REQ-032 wr_ready=1 while IDLE for 20 cycles -> no writes, busy=0, done=0.

Source files
------------

// File: rtl/game_pkg.sv
// ---------------------------------------------------------------------------
// game_pkg
// Shared constants and types for the game display path.
//   CHAR_W     : bits per character code
//   NUM_CHARS  : characters per displayed frame
//   FRAME_W    : width of a packed frame (char 0 in the MSBs)
//   ADDR_W     : width of the text-buffer character index
//   stream_state_e : frame streamer state encoding (IDLE=0, STREAM=1, DONE=2)
// ---------------------------------------------------------------------------
package game_pkg;

    localparam int CHAR_W    = 7;
    localparam int NUM_CHARS = 192;
    localparam int FRAME_W   = CHAR_W * NUM_CHARS;
    localparam int ADDR_W    = 8;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_STREAM = 2'd1,
        ST_DONE   = 2'd2
    } stream_state_e;

endpackage : game_pkg

// File: rtl/frame_char_streamer.sv
// ---------------------------------------------------------------------------
// frame_char_streamer
// Copies a whole character frame from the game FSM into the text buffer, one
// character per accepted write, using a valid/ready handshake.
//
// Ports
//   clk          : rising-edge clock
//   rst          : asynchronous active-low reset
//   frame        : packed frame, char 0 in the MSBs
//   frame_update : one-cycle request to stream the current frame
//   wr_valid     : a character write is being offered
//   wr_ready     : the text buffer accepts the offered write this cycle
//   wr_addr      : character index 0..NUM_CHARS-1
//   wr_data      : character code
//   busy         : high while streaming and during the DONE cycle
//   done         : one-cycle pulse after the last character is accepted
//
// The frame is captured into a shadow shift register so the game FSM may
// change its frame freely while streaming is in progress. Requests arriving
// while busy collapse into a single pending request that is serviced from the
// DONE cycle.
// ---------------------------------------------------------------------------
module frame_char_streamer #(
    parameter int CHAR_W    = game_pkg::CHAR_W,
    parameter int NUM_CHARS = game_pkg::NUM_CHARS
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [CHAR_W*NUM_CHARS-1:0]   frame,
    input  logic                          frame_update,
    output logic                          wr_valid,
    input  logic                          wr_ready,
    output logic [7:0]                    wr_addr,
    output logic [CHAR_W-1:0]             wr_data,
    output logic                          busy,
    output logic                          done
);

    localparam int FRAME_W = CHAR_W * NUM_CHARS;

    import game_pkg::*;

    localparam logic [7:0] LAST_ADDR = 8'(NUM_CHARS - 1);

    stream_state_e        state_q,    state_d;
    logic [FRAME_W-1:0]   shadow_q,   shadow_d;
    logic                 pending_q,  pending_d;
    logic                 wr_valid_q, wr_valid_d;
    logic [7:0]           wr_addr_q,  wr_addr_d;
    logic                 busy_q,     busy_d;
    logic                 done_q,     done_d;
    logic                 xfer;

    always_comb begin
        state_d   = state_q;
        shadow_d  = shadow_q;
        pending_d = pending_q;
        wr_addr_d = wr_addr_q;
        // A handshake only exists while a write is actually offered.
        xfer      = wr_valid_q & wr_ready;

        case (state_q)
            ST_IDLE: begin
                if (frame_update) begin
                    shadow_d  = frame;
                    wr_addr_d = 8'd0;
                    state_d   = ST_STREAM;
                end
            end

            ST_STREAM: begin
                if (frame_update) begin
                    pending_d = 1'b1;
                end
                if (xfer) begin
                    // Next character moves into the top slot; after the last
                    // shift the register is all zeros again.
                    shadow_d = shadow_q << CHAR_W;
                    if (wr_addr_q == LAST_ADDR) begin
                        wr_addr_d = 8'd0;
                        state_d   = ST_DONE;
                    end else begin
                        wr_addr_d = wr_addr_q + 8'd1;
                    end
                end
            end

            ST_DONE: begin
                // A request seen now is folded in with any earlier pending
                // one; the fresh capture happens on leaving DONE.
                if (pending_q || frame_update) begin
                    shadow_d  = frame;
                    wr_addr_d = 8'd0;
                    pending_d = 1'b0;
                    state_d   = ST_STREAM;
                end else begin
                    state_d   = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are registered copies of the next-state decode.
        wr_valid_d = (state_d == ST_STREAM);
        busy_d     = (state_d != ST_IDLE);
        done_d     = (state_d == ST_DONE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            shadow_q   <= '0;
            pending_q  <= 1'b0;
            wr_valid_q <= 1'b0;
            wr_addr_q  <= 8'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            shadow_q   <= shadow_d;
            pending_q  <= pending_d;
            wr_valid_q <= wr_valid_d;
            wr_addr_q  <= wr_addr_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign wr_valid = wr_valid_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = shadow_q[FRAME_W-1 -: CHAR_W];
    assign busy     = busy_q;
    assign done     = done_q;

endmodule : frame_char_streamer
